// File: rtl/pipe_reg_elastic.sv
// -----------------------------------------------------------------------------
// pipe_reg_elastic
//   WIDTH-bit, DEPTH-stage elastic register pipeline with valid/ready on both
//   sides. Stalls ripple backwards through a combinational ready chain, so an
//   empty stage (bubble) keeps accepting data while the output is stalled and
//   the pipeline packs down to DEPTH resident words before in_ready drops.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset (vld cleared, dat = RESET_VAL)
//   flush      synchronous clear of every valid bit (data registers hold)
//   in_valid   upstream data valid
//   in_ready   pipeline accepts in_data this cycle
//   in_data    upstream data
//   out_valid  valid bit of the last stage
//   out_ready  downstream accepts out_data
//   out_data   data register of the last stage
//   occupancy  registered count of valid stages, 0..DEPTH
// -----------------------------------------------------------------------------

// One register slice: a valid bit and a data word. The stage advances whenever
// its ready input is high; the data word only loads alongside a valid word so
// stale or undriven upstream data never enters the register.
module pipe_reg_elastic_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             up_vld,
    input  logic [WIDTH-1:0] up_dat,
    input  logic             rdy,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld <= 1'b0;
            dat <= RESET_VAL;
        end else if (flush) begin
            // Contents are discarded; data keeps its value to avoid toggling.
            vld <= 1'b0;
        end else if (rdy) begin
            vld <= up_vld;
            if (up_vld) begin
                dat <= up_dat;
            end
        end
    end

endmodule

module pipe_reg_elastic #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CW = $clog2(DEPTH + 1);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("pipe_reg_elastic: WIDTH must be >= 1");
        end
        if (DEPTH < 1) begin : g_bad_depth
            $error("pipe_reg_elastic: DEPTH must be >= 1");
        end
    endgenerate

    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][WIDTH-1:0] dat;
    // rdy[i]: stage i may take a new value this edge. rdy[DEPTH] is the sink.
    logic [DEPTH:0]              rdy;

    assign rdy[DEPTH] = out_ready;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            logic             up_vld;
            logic [WIDTH-1:0] up_dat;

            // An empty stage is always ready, which is what collapses bubbles
            // while the output is stalled.
            assign rdy[i] = ~vld[i] | rdy[i+1];

            if (i == 0) begin : g_head
                assign up_vld = in_valid;
                assign up_dat = in_data;
            end else begin : g_body
                assign up_vld = vld[i-1];
                assign up_dat = dat[i-1];
            end

            pipe_reg_elastic_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk    (clk),
                .resetn (resetn),
                .flush  (flush),
                .up_vld (up_vld),
                .up_dat (up_dat),
                .rdy    (rdy[i]),
                .vld    (vld[i]),
                .dat    (dat[i])
            );
        end
    endgenerate

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

    // Occupancy tracks handshakes rather than popcounting vld, keeping it a
    // simple up/down counter; it agrees with the valid bits by construction.
    logic          in_xfer;
    logic          out_xfer;
    logic [CW-1:0] cnt;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (in_xfer && !out_xfer) begin
            cnt <= cnt + CW'(1);
        end else if (!in_xfer && out_xfer) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign occupancy = cnt;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
module tb_pipe_reg_elastic;

    localparam int         W  = 8;
    localparam int         D  = 4;
    localparam logic [7:0] RV = 8'hA5;

    logic         clk;
    logic         resetn;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   occupancy;

    pipe_reg_elastic #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_occ;
    } vec_t;

    vec_t       vt[$];
    logic [7:0] sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic vec_t mk(logic iv, logic [7:0] d, logic ordy, logic fl,
                                logic ir, logic ov, logic [7:0] od, logic [2:0] occ);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.e_ir = ir; v.e_ov = ov; v.e_od = od; v.e_occ = occ;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called away from the edge with inputs already driven: records which
    // handshakes will fire, crosses the edge, then updates the scoreboard.
    task automatic tick();
        logic       ix, ox, fx;
        logic [7:0] id, od;
        ix = in_valid & in_ready;
        ox = out_valid & out_ready;
        fx = flush;
        id = in_data;
        od = out_data;
        @(posedge clk);
        if (resetn) begin
            if (ox) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_out: got %0h expected nothing (queue empty)", od);
                end else begin
                    chk("sb_out", {24'd0, od}, {24'd0, sb.pop_front()});
                end
            end
            if (fx) sb.delete();
            if (ix) sb.push_back(id);
        end
        @(negedge clk);
    endtask

    initial begin
        bit seen;

        // Streaming, out_ready held high.
        vt.push_back(mk(1, 8'h01, 1, 0, 1, 0, 8'h00, 0));
        vt.push_back(mk(1, 8'h02, 1, 0, 1, 0, 8'h00, 1));
        vt.push_back(mk(1, 8'h03, 1, 0, 1, 0, 8'h00, 2));
        vt.push_back(mk(1, 8'h04, 1, 0, 1, 0, 8'h00, 3));
        vt.push_back(mk(1, 8'h05, 1, 0, 1, 1, 8'h01, 4));
        vt.push_back(mk(1, 8'h06, 1, 0, 1, 1, 8'h02, 4));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h03, 4));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h04, 3));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h05, 2));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h06, 1));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0));
        // Backpressure with a bubble, then release.
        vt.push_back(mk(1, 8'h10, 0, 0, 1, 0, 8'h00, 0));
        vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 1));
        vt.push_back(mk(1, 8'h11, 0, 0, 1, 0, 8'h00, 1));
        vt.push_back(mk(1, 8'h12, 0, 0, 1, 0, 8'h00, 2));
        vt.push_back(mk(1, 8'h13, 0, 0, 1, 1, 8'h10, 3));
        vt.push_back(mk(1, 8'h14, 0, 0, 0, 1, 8'h10, 4));
        vt.push_back(mk(1, 8'h14, 0, 0, 0, 1, 8'h10, 4));
        vt.push_back(mk(1, 8'h14, 1, 0, 1, 1, 8'h10, 4));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h11, 4));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h12, 3));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h13, 2));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h14, 1));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0));
        // Fill, then simultaneous in/out while full.
        vt.push_back(mk(1, 8'h20, 0, 0, 1, 0, 8'h00, 0));
        vt.push_back(mk(1, 8'h21, 0, 0, 1, 0, 8'h00, 1));
        vt.push_back(mk(1, 8'h22, 0, 0, 1, 0, 8'h00, 2));
        vt.push_back(mk(1, 8'h23, 0, 0, 1, 0, 8'h00, 3));
        vt.push_back(mk(1, 8'h24, 1, 0, 1, 1, 8'h20, 4));
        vt.push_back(mk(1, 8'h25, 1, 0, 1, 1, 8'h21, 4));
        vt.push_back(mk(1, 8'h26, 1, 0, 1, 1, 8'h22, 4));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h23, 4));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h24, 3));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h25, 2));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h26, 1));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0));
        // Flush with three resident words, then the pipe still works.
        vt.push_back(mk(1, 8'h30, 0, 0, 1, 0, 8'h00, 0));
        vt.push_back(mk(1, 8'h31, 0, 0, 1, 0, 8'h00, 1));
        vt.push_back(mk(1, 8'h32, 0, 0, 1, 0, 8'h00, 2));
        vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 3));
        vt.push_back(mk(1, 8'h33, 0, 1, 0, 1, 8'h30, 3));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0));
        vt.push_back(mk(1, 8'h40, 1, 0, 1, 0, 8'h00, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h40, 1));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0));
        // Flush coinciding with an output transfer.
        vt.push_back(mk(1, 8'h41, 0, 0, 1, 0, 8'h00, 0));
        vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 1));
        vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 1));
        vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 1));
        vt.push_back(mk(0, 8'h00, 1, 1, 0, 1, 8'h41, 1));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0));

        flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
        resetn = 1'b1;
        #1 resetn = 1'b0;

        // Reset: two edges held, checked during and right after release.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_data",  {24'd0, out_data},  {24'd0, RV});
            chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
            chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        end
        resetn = 1'b1;
        #1;
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_out_data",  {24'd0, out_data},  {24'd0, RV});
        chk("post_rst_occupancy", {29'd0, occupancy}, 32'd0);
        chk("post_rst_in_ready",  {31'd0, in_ready},  32'd1);

        foreach (vt[i]) begin
            in_valid  = vt[i].iv;
            in_data   = vt[i].d;
            out_ready = vt[i].ordy;
            flush     = vt[i].fl;
            #1;
            chk($sformatf("row%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vt[i].e_ir});
            chk($sformatf("row%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vt[i].e_ov});
            chk($sformatf("row%0d_occupancy", i), {29'd0, occupancy}, {29'd0, vt[i].e_occ});
            if (vt[i].e_ov)
                chk($sformatf("row%0d_out_data", i), {24'd0, out_data}, {24'd0, vt[i].e_od});
            tick();
        end
        flush = 0;
        chk("sb_empty_after_table", sb.size(), 0);

        // Mid-stream asynchronous reset.
        out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1;
            in_data  = 8'h50 + 8'(k);
            tick();
        end
        chk("mr_pre_out_valid", {31'd0, out_valid}, 32'd1);
        #3 resetn = 1'b0;
        in_valid = 0;
        #1;
        chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_out_data",  {24'd0, out_data},  {24'd0, RV});
        chk("mr_occupancy", {29'd0, occupancy}, 32'd0);
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        in_valid = 1; in_data = 8'h60; tick();
        in_valid = 1; in_data = 8'h61; tick();
        in_valid = 0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            #1;
            if (out_valid) begin
                seen = 1;
                chk("mr_first_out", {24'd0, out_data}, 32'h60);
            end
            tick();
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL mr_timeout: got no out_valid expected word 60");
        end
        for (int k = 0; k < 4; k++) tick();
        chk("sb_empty_final", sb.size(), 0);
        chk("final_occupancy", {29'd0, occupancy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
